// File: rtl/ex_mem_hazard_controller.sv
// Stall/flush/bubble sequencer for the RV32IM EX/MEM boundary: divider sequencing,
// load-use interlock, taken-branch flush and a saturating stall-cycle counter.
module ex_mem_hazard_controller #(
  parameter int DIV_LATENCY = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div_req,
  input  logic        ex_branch_taken,
  input  logic        ex_wb_load,
  input  logic [4:0]  ex_wb_rd,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_flush,
  output logic        ex_mem_bubble,
  output logic        div_start,
  output logic        div_result_valid,
  output logic [31:0] stall_count
);

  localparam int CNT_W = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [CNT_W-1:0]   cnt_next;
  logic [31:0]        stall_count_reg;
  logic               rs1_match;
  logic               rs2_match;
  logic               load_use;

  // x0 is hard-wired to zero, so a load targeting it can never feed a consumer.
  assign rs1_match = id_rs1_used && (id_rs1 == ex_wb_rd);
  assign rs2_match = id_rs2_used && (id_rs2 == ex_wb_rd);
  assign load_use  = ex_wb_load && (ex_wb_rd != 5'd0) && (rs1_match || rs2_match);

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    pc_stall         = 1'b0;
    if_id_stall      = 1'b0;
    if_id_flush      = 1'b0;
    id_ex_stall      = 1'b0;
    id_ex_flush      = 1'b0;
    ex_mem_bubble    = 1'b0;
    div_start        = 1'b0;
    div_result_valid = 1'b0;

    if (!rst) begin
      unique case (state_reg)
        IDLE: begin
          if (ex_div_req) begin
            div_start     = 1'b1;
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_bubble = 1'b1;
            cnt_next      = CNT_W'(DIV_LATENCY - 2);
            // The shortest legal latency has no busy cycles at all.
            state_next    = (DIV_LATENCY <= 2) ? DIV_DONE : DIV_BUSY;
          end else if (ex_branch_taken) begin
            // The ID instruction is wrong-path, so any hazard it shows is moot.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end
        end

        DIV_BUSY: begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_bubble = 1'b1;
          // cnt holds the busy cycles still to go, including this one.
          if (cnt_reg <= CNT_W'(1)) begin
            cnt_next   = '0;
            state_next = DIV_DONE;
          end else begin
            cnt_next   = cnt_reg - CNT_W'(1);
          end
        end

        DIV_DONE: begin
          // ex_div_req is still the same instruction here; never restart on it.
          div_result_valid = 1'b1;
          state_next       = IDLE;
        end

        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      stall_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (pc_stall && (stall_count_reg != 32'hFFFF_FFFF)) begin
        stall_count_reg <= stall_count_reg + 32'd1;
      end
    end
  end

  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_ex_mem_hazard_controller.sv
// Directed bench: a 32-cycle and a 4-cycle divider instance share the hazard inputs;
// each has its own ex_div_req so divide sequences can be shaped independently.
module tb_ex_mem_hazard_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_req32;
  logic        div_req4;
  logic        branch;
  logic        load;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_used;
  logic        rs2_used;

  logic        pc32, ifs32, iff32, ids32, idf32, bub32, start32, valid32;
  logic        pc4, ifs4, iff4, ids4, idf4, bub4, start4, valid4;
  logic [31:0] sc32;
  logic [31:0] sc4;
  logic [7:0]  out32;
  logic [7:0]  out4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_hazard_controller #(.DIV_LATENCY(32)) dut (
    .clk(clk), .rst(rst), .ex_div_req(div_req32), .ex_branch_taken(branch),
    .ex_wb_load(load), .ex_wb_rd(rd), .id_rs1(rs1), .id_rs2(rs2),
    .id_rs1_used(rs1_used), .id_rs2_used(rs2_used),
    .pc_stall(pc32), .if_id_stall(ifs32), .if_id_flush(iff32), .id_ex_stall(ids32),
    .id_ex_flush(idf32), .ex_mem_bubble(bub32), .div_start(start32),
    .div_result_valid(valid32), .stall_count(sc32)
  );

  ex_mem_hazard_controller #(.DIV_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .ex_div_req(div_req4), .ex_branch_taken(branch),
    .ex_wb_load(load), .ex_wb_rd(rd), .id_rs1(rs1), .id_rs2(rs2),
    .id_rs1_used(rs1_used), .id_rs2_used(rs2_used),
    .pc_stall(pc4), .if_id_stall(ifs4), .if_id_flush(iff4), .id_ex_stall(ids4),
    .id_ex_flush(idf4), .ex_mem_bubble(bub4), .div_start(start4),
    .div_result_valid(valid4), .stall_count(sc4)
  );

  // Bit order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
  // ex_mem_bubble, div_start, div_result_valid.
  assign out32 = {pc32, ifs32, iff32, ids32, idf32, bub32, start32, valid32};
  assign out4  = {pc4, ifs4, iff4, ids4, idf4, bub4, start4, valid4};

  localparam logic [7:0] O_START  = 8'b1101_0110;
  localparam logic [7:0] O_BUSY   = 8'b1101_0100;
  localparam logic [7:0] O_DONE   = 8'b0000_0001;
  localparam logic [7:0] O_HAZARD = 8'b1100_1000;
  localparam logic [7:0] O_FLUSH  = 8'b0010_1000;
  localparam logic [7:0] O_NONE   = 8'b0000_0000;

  typedef struct {
    logic       br;
    logic       ld;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  // Expected controls k cycles after a divide request that is held for `win` cycles
  // (win a multiple of lat), i.e. win/lat back-to-back divides.
  function automatic logic [7:0] div_exp(input int k, input int lat, input int win);
    int p;
    if (k >= win) return O_NONE;
    p = k % lat;
    if (p == 0) return O_START;
    if (p == lat - 1) return O_DONE;
    return O_BUSY;
  endfunction

  logic [31:0] sc_model;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, O_NONE};
    vecs[1] = '{1'b0, 1'b1, 5'd5,  5'd0, 5'd5,  1'b0, 1'b1, O_HAZARD};
    vecs[2] = '{1'b0, 1'b1, 5'd0,  5'd0, 5'd0,  1'b1, 1'b1, O_NONE};
    vecs[3] = '{1'b0, 1'b1, 5'd5,  5'd0, 5'd5,  1'b0, 1'b0, O_NONE};
    vecs[4] = '{1'b0, 1'b1, 5'd7,  5'd7, 5'd1,  1'b1, 1'b0, O_HAZARD};
    vecs[5] = '{1'b0, 1'b0, 5'd7,  5'd7, 5'd7,  1'b1, 1'b1, O_NONE};
    vecs[6] = '{1'b1, 1'b1, 5'd5,  5'd0, 5'd5,  1'b0, 1'b1, O_FLUSH};
    vecs[7] = '{1'b1, 1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, O_FLUSH};
    vecs[8] = '{1'b0, 1'b1, 5'd3,  5'd4, 5'd5,  1'b1, 1'b1, O_NONE};
    vecs[9] = '{1'b0, 1'b1, 5'd31, 5'd31, 5'd31, 1'b0, 1'b1, O_HAZARD};

    rst = 1'b1; div_req32 = 1'b1; div_req4 = 1'b1;
    branch = 1'b0; load = 1'b0; rd = '0; rs1 = '0; rs2 = '0;
    rs1_used = 1'b0; rs2_used = 1'b0;

    // Reset held with a divide request pending: everything stays quiet.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check("reset_out32", {24'd0, out32}, {24'd0, O_NONE});
      check("reset_out4", {24'd0, out4}, {24'd0, O_NONE});
      check("reset_sc32", sc32, 32'd0);
    end

    // Single divide on the 32-cycle unit, two back-to-back on the 4-cycle unit.
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      rst = 1'b0;
      div_req32 = (k < 32);
      div_req4  = (k < 8);
      #1;
      check($sformatf("div32_k%0d", k), {24'd0, out32}, {24'd0, div_exp(k, 32, 32)});
      check($sformatf("div4_k%0d", k), {24'd0, out4}, {24'd0, div_exp(k, 4, 8)});
    end
    @(negedge clk);
    check("div32_stall_count", sc32, 32'd31);
    check("div4_stall_count", sc4, 32'd6);

    // Hazard/branch vectors in IDLE; stall_count advances only on pc_stall.
    sc_model = 32'd31;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      branch = vecs[i].br; load = vecs[i].ld; rd = vecs[i].rd;
      rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
      rs1_used = vecs[i].u1; rs2_used = vecs[i].u2;
      #1;
      check($sformatf("vec%0d_out", i), {24'd0, out32}, {24'd0, vecs[i].exp});
      if (vecs[i].exp[7]) sc_model = sc_model + 32'd1;
      @(negedge clk);
      branch = 1'b0; load = 1'b0; rs1_used = 1'b0; rs2_used = 1'b0;
      #1;
      check($sformatf("vec%0d_sc", i), sc32, sc_model);
      check($sformatf("vec%0d_after", i), {24'd0, out32}, {24'd0, O_NONE});
    end

    // Reset in the middle of a division abandons it without a result.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      div_req32 = 1'b1;
      #1;
      check($sformatf("abort_k%0d", k), {24'd0, out32}, {24'd0, div_exp(k, 32, 32)});
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_rst_out", {24'd0, out32}, {24'd0, O_NONE});
    @(negedge clk);
    rst = 1'b0; div_req32 = 1'b0;
    #1;
    check("abort_idle_out", {24'd0, out32}, {24'd0, O_NONE});
    check("abort_sc", sc32, 32'd0);
    begin
      int valid_seen = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk); #1;
        if (valid32) valid_seen++;
      end
      check("abort_no_valid", valid_seen, 32'd0);
    end

    // A fresh request after the abort runs a full-latency divide.
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      div_req32 = (k < 32);
      #1;
      check($sformatf("restart_k%0d", k), {24'd0, out32}, {24'd0, div_exp(k, 32, 32)});
    end
    @(negedge clk);
    check("restart_stall_count", sc32, 32'd31);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
